// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: shared constants, state encoding and mem I/O offsets for the SD SPI master.
package sd_spi_pkg;
    localparam int DIV_W = 8;
    localparam logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(124);
    localparam logic [3:0] SD_DATA_OFS = 4'h0;
    localparam logic [3:0] SD_DIV_OFS = 4'h4;
    localparam logic [3:0] SD_CS_OFS = 4'h8;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage

// File: rtl/sd_spi_tick.sv
// sd_spi_tick: reloadable down-counter timing each SCK half-period; tick when it reaches zero.
module sd_spi_tick
    import sd_spi_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DIV_W-1:0] reload,
    output logic             tick
);
    logic [DIV_W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= reload;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end
    assign tick = cnt == '0;
endmodule

// File: rtl/sd_spi_master.sv
// sd_spi_master: byte-wide SPI mode 0 master, MSB first, with CPU-set divisor and chip select.
module sd_spi_master
    import sd_spi_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wen,
    input  logic [7:0]       wdata,
    input  logic             div_wen,
    input  logic [DIV_W-1:0] div_in,
    input  logic             cs_wen,
    input  logic             cs_in,
    output logic [7:0]       rdata,
    output logic             busy,
    output logic             done,
    output logic             sd_spi_cs,
    output logic             sd_spi_clk,
    output logic             sd_spi_mosi,
    input  logic             sd_spi_miso
);
    state_t state, state_nxt;
    logic [DIV_W-1:0] div, div_lat;
    logic [7:0] shreg;
    logic [2:0] bitcnt;
    logic rxbit, tick, start, edge_due;
    assign start = state == IDLE && wen;
    assign edge_due = tick && (state == LOW || state == HIGH);
    // the divisor register may change mid-transfer; reloads use the copy taken at start
    sd_spi_tick tick_u (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (start || edge_due),
        .reload (start ? div : div_lat),
        .tick   (tick)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = wen ? LOW : IDLE;
            LOW:  state_nxt = tick ? HIGH : LOW;
            HIGH: state_nxt = !tick ? HIGH : (bitcnt == 3'd0 ? DONE : LOW);
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sd_spi_cs <= 1'b1;
            sd_spi_clk <= 1'b0;
            sd_spi_mosi <= 1'b1;
            busy <= 1'b0;
            done <= 1'b0;
            rdata <= 8'h00;
            div <= DEFAULT_DIV;
            div_lat <= DEFAULT_DIV;
            shreg <= 8'h00;
            bitcnt <= 3'd0;
            rxbit <= 1'b0;
        end else begin
            if (div_wen) div <= div_in;
            if (cs_wen) sd_spi_cs <= cs_in;
            done <= state == DONE;
            busy <= state_nxt != IDLE;
            if (start) begin
                shreg <= wdata;
                sd_spi_mosi <= wdata[7];
                bitcnt <= 3'd7;
                div_lat <= div;
                sd_spi_clk <= 1'b0;
            end
            if (state == LOW && tick) begin
                sd_spi_clk <= 1'b1;
                rxbit <= sd_spi_miso;
            end
            // falling edge: shift in the sampled bit and launch the next one
            if (state == HIGH && tick) begin
                sd_spi_clk <= 1'b0;
                shreg <= {shreg[6:0], rxbit};
                if (bitcnt != 3'd0) begin
                    bitcnt <= bitcnt - 1'b1;
                    sd_spi_mosi <= shreg[6];
                end
            end
            if (state == DONE) begin
                rdata <= shreg;
                sd_spi_mosi <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sd_spi_master.sv
// tb_sd_spi_master: directed bench with an rdata scoreboard and SCK/MOSI/timing monitor.
module tb_sd_spi_master;
    import sd_spi_pkg::*;
    logic clk = 0, rst_n = 0, wen = 0, div_wen = 0, cs_wen = 0, cs_in = 1;
    logic loop = 0, miso_val = 0;
    logic [7:0] wdata = 0;
    logic [DIV_W-1:0] div_in = 0;
    logic [7:0] rdata;
    logic busy, done, cs, sck, mosi, miso;
    int errors = 0, checks = 0, cyc = 0, e0 = 0, done_cyc = 0, done_cnt = 0;
    int rises = 0, busy_cyc = 0, n0 = 0;
    int rise_cyc[8];
    logic prev_sck = 0, cs_hi = 0;
    logic [7:0] mosi_bits = 0;
    logic [7:0] sb[$];
    assign miso = loop ? mosi : miso_val;
    sd_spi_master dut (
        .clk(clk), .rst_n(rst_n), .wen(wen), .wdata(wdata),
        .div_wen(div_wen), .div_in(div_in), .cs_wen(cs_wen), .cs_in(cs_in),
        .rdata(rdata), .busy(busy), .done(done), .sd_spi_cs(cs),
        .sd_spi_clk(sck), .sd_spi_mosi(mosi), .sd_spi_miso(miso)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask
    always @(negedge clk) begin
        if (sck && !prev_sck) begin
            if (rises < 8) begin
                rise_cyc[rises] = cyc;
                mosi_bits[7 - rises] = mosi;
            end
            rises++;
        end
        prev_sck = sck;
        if (busy) busy_cyc++;
        if (busy && cs) cs_hi = 1;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check("sb_has_entry", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) check("rdata", rdata, sb.pop_front());
        end
    end
    task automatic start(input logic [7:0] b, input logic push, input logic [7:0] exp, input logic set_cs);
        @(negedge clk);
        wen = 1; wdata = b; cs_wen = set_cs; cs_in = 0;
        e0 = cyc + 1; rises = 0; busy_cyc = 0; cs_hi = 0; mosi_bits = 0;
        if (push) sb.push_back(exp);
        @(negedge clk);
        wen = 0; cs_wen = 0;
    endtask
    task automatic set_div(input logic [DIV_W-1:0] v);
        @(negedge clk); div_wen = 1; div_in = v;
        @(negedge clk); div_wen = 0;
    endtask
    task automatic wait_done(input int limit);
        int n = done_cnt;
        for (int i = 0; i < limit && done_cnt == n; i++) begin
            @(negedge clk); #1;
        end
        check("done_seen", 32'(done_cnt != n), 1);
    endtask
    task automatic check_reset(input string tag);
        check({tag, "_cs"}, cs, 1);
        check({tag, "_sck"}, sck, 0);
        check({tag, "_mosi"}, mosi, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rdata"}, rdata, 0);
    endtask
    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1;
        check_reset("rst");
        repeat (100) @(negedge clk);
        check("idle_rises", rises, 0);
        // loopback, div=0
        set_div(0); loop = 1;
        start(8'hA5, 1, 8'hA5, 0);
        wait_done(100);
        check("lb_rises", rises, 8);
        check("lb_mosi", mosi_bits, 8'hA5);
        check("lb_lat", done_cyc - e0, 17);
        check("lb_busy", busy_cyc, 17);
        check("lb_rise0", rise_cyc[0] - e0, 1);
        // miso high, div=3
        loop = 0; miso_val = 1;
        set_div(3);
        start(8'h00, 1, 8'hFF, 0);
        wait_done(200);
        check("d3_mosi", mosi_bits, 8'h00);
        check("d3_rise0", rise_cyc[0] - e0, 4);
        check("d3_span", rise_cyc[7] - rise_cyc[0], 56);
        check("d3_lat", done_cyc - e0, 65);
        check("d3_idle_mosi", mosi, 1);
        // default divisor after reset
        @(negedge clk); rst_n = 0;
        repeat (2) @(negedge clk); rst_n = 1;
        miso_val = 0;
        start(8'h3C, 1, 8'h00, 0);
        wait_done(2500);
        check("def_rise0", rise_cyc[0] - e0, 125);
        check("def_lat", done_cyc - e0, 2001);
        check("def_mosi", mosi_bits, 8'h3C);
        // ignored second wen and mid-transfer divisor write
        set_div(1); loop = 1;
        n0 = done_cnt;
        start(8'h11, 1, 8'h11, 0);
        repeat (4) @(negedge clk);
        wen = 1; wdata = 8'h22; div_wen = 1; div_in = 0;
        @(negedge clk); wen = 0; div_wen = 0;
        wait_done(100);
        check("ign_rises", rises, 8);
        check("ign_lat", done_cyc - e0, 33);
        check("ign_mosi", mosi_bits, 8'h11);
        repeat (40) @(negedge clk);
        check("ign_dones", done_cnt - n0, 1);
        start(8'h5A, 1, 8'h5A, 0);
        wait_done(50);
        check("newdiv_lat", done_cyc - e0, 17);
        // abort after the 3rd SCK rise
        start(8'hC3, 0, 8'h00, 0);
        for (int i = 0; i < 200 && rises < 3; i++) @(negedge clk);
        check("abort_reached", 32'(rises >= 3), 1);
        rst_n = 0;
        @(negedge clk);
        check_reset("abort");
        rst_n = 1;
        n0 = done_cnt;
        repeat (60) @(negedge clk);
        check("abort_no_done", done_cnt - n0, 0);
        // cs_wen together with wen
        set_div(0);
        start(8'hFF, 1, 8'hFF, 1);
        wait_done(50);
        check("cs_lat", done_cyc - e0, 17);
        check("cs_hi_seen", cs_hi, 0);
        check("cs_level", cs, 0);
        check("cs_rises", rises, 8);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sd_spi_master.md
Name: sd_spi_master

Overview:
- Byte-wide SPI master between the memory-mapped I/O decode in mem and the SD card pins: sd_spi_cs, sd_spi_clk, sd_spi_mosi, sd_spi_miso.
- The CPU writes a transmit byte, chip-select level and clock divisor. The block shifts out one byte in SPI mode 0, MSB first, and captures the received byte at the same time.
- It reports completion with busy and a one-cycle done pulse, which mem ORs into the interrupt vector.

Parameters:
- DEFAULT_DIV, 124: half-period divisor loaded at reset. SCK = clk / (2*(div+1)), so 400 kHz at 100 MHz for SD init.
- DIV_W, 8: width of the divisor register.

Ports:
- clk  in  1  system clock (the only clock).
- rst_n  in  1  synchronous, active-low reset.
- wen  in  1  start strobe; wdata is latched and a transfer starts.
- wdata  in  8  byte to transmit.
- div_wen  in  1  divisor write strobe.
- div_in  in  DIV_W  new divisor value.
- cs_wen  in  1  chip-select write strobe.
- cs_in  in  1  new chip-select level (1 = deasserted).
- rdata  out  8  last received byte.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse (interrupt source).
- sd_spi_cs  out  1  card chip select, active low.
- sd_spi_clk  out  1  SCK.
- sd_spi_mosi  out  1  master out.
- sd_spi_miso  in  1  master in; already synchronous in this design, no synchroniser.

Behaviour:
- Reset values (rst_n low at a clk edge):
  - sd_spi_cs=1, sd_spi_clk=0, sd_spi_mosi=1, busy=0, done=0, rdata=8'h00.
  - div=DEFAULT_DIV, state IDLE.
  - Reset mid-transfer aborts immediately: no done pulse, rdata is cleared.
- Register writes:
  - div_wen writes div in any state. A running transfer keeps the divisor latched at its start.
  - cs_wen writes sd_spi_cs in any state, including mid-transfer. It is never changed automatically.
  - If wen and cs_wen arrive in the same cycle, both take effect on the same edge.
- States: IDLE, LOW, HIGH, DONE. Every transition is on a clk edge.
  - IDLE, wen=1: shreg <= wdata, mosi <= wdata[7], bitcnt <= 7, cnt <= div, sck=0, busy <= 1, go to LOW.
  - IDLE, wen=0: hold.
  - LOW: while cnt != 0, cnt <= cnt-1. At cnt==0: sck <= 1, rxbit <= miso (sampled on the rising edge), cnt <= div, go to HIGH.
  - HIGH: while cnt != 0, cnt <= cnt-1. At cnt==0: sck <= 0 and shreg <= {shreg[6:0], rxbit}.
    - If bitcnt==0: go to DONE.
    - Else: bitcnt <= bitcnt-1, mosi <= shreg[6] (next bit, launched on the falling edge), go to LOW.
  - DONE (one cycle): rdata <= shreg, done <= 1, busy <= 0, mosi <= 1, go to IDLE. done is 0 in every other cycle.
- Timing:
  - Each SCK half lasts exactly div+1 clk cycles. div=0 is legal and gives clk/2.
  - wen is sampled at edge E0. The first SCK rise is at edge E0+(div+1). The 8th SCK fall is at edge E0+16(div+1).
  - done and busy fall both follow edge E0+16(div+1)+1. Total latency is 16(div+1)+1 cycles; 17 cycles when div=0.
  - A new wen is accepted in the cycle done is high, because the state is IDLE after that edge.
- wen while busy (LOW, HIGH or DONE) is ignored: no queueing, and the current transfer is unaffected.
- Exactly 8 SCK rising edges occur per transfer. SCK idles low and MOSI idles high between transfers.
- Arithmetic: cnt is DIV_W bits and is only decremented when non-zero, so it cannot wrap. bitcnt is 3 bits.

Decomposition:
- Package sd_spi_pkg holds:
  - the state enum (IDLE=2'd0, LOW=2'd1, HIGH=2'd2, DONE=2'd3);
  - the DEFAULT_DIV and DIV_W constants;
  - the I/O offsets used by mem for data, divisor and CS.
- One sub-module, sd_spi_tick: a DIV_W-bit reloadable down-counter with inputs load and reload value, and output tick (cnt==0). It is instantiated once.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> cs=1, sck=0, mosi=1, busy=0, done=0, rdata=8'h00; no SCK activity for 100 cycles.
- Loopback, div=0: miso wired to mosi, write 8'hA5 -> 8 SCK rises; mosi bits 1,0,1,0,0,1,0,1 at the rises; done pulses 17 cycles after wen; rdata=8'hA5; busy high for 17 cycles.
- miso tied 1, div=3, tx 8'h00 -> mosi=0 at every rise, rdata=8'hFF, SCK half-period 4 cycles, done 65 cycles after wen.
- Default divisor after reset, tx 8'h3C with miso tied 0 -> SCK half-period 125 cycles, done 2001 cycles after wen, rdata=8'h00.
- wen 8'h11 accepted, then wen 8'h22 five cycles later, plus div_wen=0 mid-transfer (initial div=1) -> second wen ignored; exactly 8 SCK rises; latency stays 33; the next transfer runs with div=0.
- Abort: rst_n=0 after the 3rd SCK rise -> all outputs at reset values on the next edge, no done pulse; cs_wen 0 together with wen 8'hFF then gives a normal transfer with cs=0 throughout.
